// File: rtl/tx_interleaver_pkg.sv
// Shared constants, mode codes and per-mode lookup tables for the 802.11a TX interleaver.
package tx_interleaver_pkg;

    localparam int NCBPS_MAX = 288;
    localparam int AW        = 9;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'b00,
        MOD_QPSK  = 2'b01,
        MOD_16QAM = 2'b10,
        MOD_64QAM = 2'b11
    } modE;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rdStateE;

    function automatic logic [AW-1:0] ncbps(input modE m);
        logic [AW-1:0] r;
        case (m)
            MOD_BPSK:  r = 9'd48;
            MOD_QPSK:  r = 9'd96;
            MOD_16QAM: r = 9'd192;
            default:   r = 9'd288;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] sVal(input modE m);
        logic [1:0] r;
        case (m)
            MOD_16QAM: r = 2'd2;
            MOD_64QAM: r = 2'd3;
            default:   r = 2'd1;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] nDiv16(input modE m);
        logic [4:0] r;
        case (m)
            MOD_BPSK:  r = 5'd3;
            MOD_QPSK:  r = 5'd6;
            MOD_16QAM: r = 5'd12;
            default:   r = 5'd18;
        endcase
        return r;
    endfunction

    // Residue mod 3 by summing base-4 digits (4 == 1 mod 3), no divider needed.
    function automatic logic [1:0] mod3(input logic [AW-1:0] v);
        logic [3:0] s1;
        logic [2:0] s2;
        logic [1:0] s3;
        s1 = 4'(v[1:0]) + 4'(v[3:2]) + 4'(v[5:4]) + 4'(v[7:6]) + 4'(v[8]);
        s2 = 3'(s1[1:0]) + 3'(s1[3:2]);
        s3 = s2[1:0] + 2'(s2[2]);
        return (s3 == 2'd3) ? 2'd0 : s3;
    endfunction

endpackage

// File: rtl/tx_interleaver_addr_gen.sv
// Combinational write-address generator: maps the (col,row) position of input bit k to its
// permuted bank address j using the two-step 802.11a interleaver permutation.
module intlv_addr_gen
    import tx_interleaver_pkg::*;
(
    input  modE           mode,
    input  logic [3:0]    col,
    input  logic [4:0]    row,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] iIdx;
    logic [1:0]    iMod3;
    logic [1:0]    colMod3;
    logic [1:0]    rem3;

    // floor(16*i/N) equals col, so the second-step rotation only needs col and i.
    always_comb begin
        iIdx    = AW'(nDiv16(mode)) * AW'(col) + AW'(row);
        iMod3   = mod3(iIdx);
        colMod3 = mod3(AW'(col));
        rem3    = (iMod3 >= colMod3) ? (iMod3 - colMod3) : (iMod3 + 2'd3 - colMod3);
        case (sVal(mode))
            2'd1:    addr = iIdx;
            2'd2:    addr = {iIdx[AW-1:1], iIdx[0] ^ col[0]};
            default: addr = iIdx - AW'(iMod3) + AW'(rem3);
        endcase
    end

endmodule

// File: rtl/tx_interleaver.sv
// 802.11a TX block interleaver: serial coded bits are written permuted into a ping-pong
// bit buffer and each completed symbol is streamed out in address order.
module tx_interleaver
    import tx_interleaver_pkg::*;
(
    input  logic       iFClk,
    input  logic       iRst,
    input  logic       iEN,
    input  logic [1:0] iMod,
    input  logic       iData,
    input  logic       iValid,
    output logic       oData,
    output logic       oValid
);

    logic [NCBPS_MAX-1:0] mem [2];

    logic [AW-1:0] wrCnt;
    logic [3:0]    wrCol;
    logic [4:0]    wrRow;
    logic          wrBank;
    modE           wrMode;
    modE           bankMode [2];
    logic [1:0]    full;

    rdStateE       rdState;
    logic          rdBank;
    logic [AW-1:0] rdAddr;
    logic [AW-1:0] rdLast;

    logic          take;
    modE           curMode;
    logic          lastWr;
    logic          clrFull;
    logic [AW-1:0] wrAddr;

    assign take    = iEN && iValid;
    assign curMode = (wrCnt == '0) ? modE'(iMod) : wrMode;
    assign lastWr  = take && (wrCnt == ncbps(curMode) - AW'(1));
    assign clrFull = (rdState == RD_READ) && (rdAddr == rdLast);

    intlv_addr_gen uAddrGen (
        .mode (curMode),
        .col  (wrCol),
        .row  (wrRow),
        .addr (wrAddr)
    );

    always_ff @(posedge iFClk) begin
        if (take) begin
            mem[wrBank][wrAddr] <= iData;
        end
    end

    // Write side: col counts k mod 16, row counts floor(k/16); dropping iEN discards the partial symbol.
    always_ff @(posedge iFClk or posedge iRst) begin
        if (iRst) begin
            wrCnt       <= '0;
            wrCol       <= '0;
            wrRow       <= '0;
            wrBank      <= 1'b0;
            wrMode      <= MOD_BPSK;
            bankMode[0] <= MOD_BPSK;
            bankMode[1] <= MOD_BPSK;
        end else if (!iEN) begin
            wrCnt <= '0;
            wrCol <= '0;
            wrRow <= '0;
        end else if (take) begin
            if (wrCnt == '0) begin
                wrMode           <= curMode;
                bankMode[wrBank] <= curMode;
            end
            if (lastWr) begin
                wrCnt  <= '0;
                wrCol  <= '0;
                wrRow  <= '0;
                wrBank <= ~wrBank;
            end else begin
                wrCnt <= wrCnt + AW'(1);
                wrCol <= wrCol + 4'd1;
                if (wrCol == 4'd15) begin
                    wrRow <= wrRow + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge iFClk or posedge iRst) begin
        if (iRst) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (lastWr && (wrBank == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (clrFull && (rdBank == 1'(b))) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    // Read side: IDLE already emits address 0, so a waiting full bank follows the last bit with no gap.
    always_ff @(posedge iFClk or posedge iRst) begin
        if (iRst) begin
            rdState <= RD_IDLE;
            rdBank  <= 1'b0;
            rdAddr  <= '0;
            rdLast  <= '0;
            oData   <= 1'b0;
            oValid  <= 1'b0;
        end else begin
            case (rdState)
                RD_IDLE: begin
                    if (full[rdBank]) begin
                        oData   <= mem[rdBank][0];
                        oValid  <= 1'b1;
                        rdAddr  <= AW'(1);
                        rdLast  <= ncbps(bankMode[rdBank]) - AW'(1);
                        rdState <= RD_READ;
                    end else begin
                        oData  <= 1'b0;
                        oValid <= 1'b0;
                    end
                end
                default: begin
                    oData  <= mem[rdBank][rdAddr];
                    oValid <= 1'b1;
                    if (rdAddr == rdLast) begin
                        rdAddr  <= '0;
                        rdBank  <= ~rdBank;
                        rdState <= RD_IDLE;
                    end else begin
                        rdAddr <= rdAddr + AW'(1);
                    end
                end
            endcase
        end
    end

    // Writing into a bank that has not been fully read out would corrupt the pending symbol.
    assert property (@(posedge iFClk) disable iff (iRst) !(take && full[wrBank]));

endmodule
